// File: rtl/memory_interface_pkg.sv
// Shared memory definitions: default geometry, wait-state count and FSM encoding.
package memory_interface_pkg;

    localparam int MEM_DEPTH       = 512;
    localparam int MEM_ADDR_W      = 9;
    localparam int MEM_WAIT_STATES = 2;
    localparam int MEM_DATA_W      = 32;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } mem_state_e;

endpackage

// File: rtl/memory_interface_ram.sv
// Single-port synchronous RAM: registered read data, write on we.
// Contents are never cleared; they persist across the controller reset.
module ram_512x32 #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] dout_q;

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout_q <= mem_q[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/memory_interface.sv
// Memory interface controller: MAR, request FSM with wait-state timer,
// and the storage array behind it.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | waiting for a Read or Write request
// ST_RD_WAIT | read accepted, counting down wait states
// ST_WR_WAIT | write accepted, counting down wait states
// ST_DONE    | request complete, mem_ready high for this cycle
module memory_interface
    import memory_interface_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WAIT_STATES = MEM_WAIT_STATES
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] bus_contents,
    input  logic        MARin,
    input  logic [31:0] MDR_data_out,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] MDatain,
    output logic [31:0] MAR_data_out,
    output logic        mem_busy,
    output logic        mem_ready,
    output logic        mem_err
);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mar_q, mar_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mdatain_q, mdatain_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_dout;

    // Next-state, MAR load and RAM control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mar_d     = mar_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mdatain_d = mdatain_q;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;

        // A request on the same edge as a MAR load uses the new bus value.
        req_addr = MARin ? bus_contents[ADDR_W-1:0] : mar_q[ADDR_W-1:0];

        if (MARin) begin
            mar_d = bus_contents;
        end

        case (state_q)
            ST_IDLE: begin
                // Present the request address now so read data is ready
                // even with zero wait states.
                ram_addr = req_addr;
                if (Read && Write) begin
                    err_d = 1'b1;
                end else if (Read) begin
                    addr_d  = req_addr;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ST_RD_WAIT;
                end else if (Write) begin
                    addr_d  = req_addr;
                    wdata_d = MDR_data_out;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ST_WR_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mdatain_d = ram_dout;
                    state_d   = ST_DONE;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ram_we  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An aborted write must not reach the array.
        if (clr) begin
            ram_we = 1'b0;
        end
    end

    // Controller registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mar_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mdatain_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mar_q     <= mar_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mdatain_q <= mdatain_d;
            err_q     <= err_d;
        end
    end

    ram_512x32 #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    assign MDatain      = mdatain_q;
    assign MAR_data_out = mar_q;
    assign mem_busy     = (state_q != ST_IDLE);
    assign mem_ready    = (state_q == ST_DONE);
    assign mem_err      = err_q;

endmodule

// File: tb/tb_memory_interface.sv
// Scoreboard bench for memory_interface: directed scenarios then random traffic
// against a transaction-level model of the memory and request timing.
module tb_memory_interface;
    import memory_interface_pkg::*;

    localparam int WS = MEM_WAIT_STATES;

    logic        clk = 1'b0;
    logic        clr, MARin, Read, Write;
    logic [31:0] bus_contents, MDR_data_out;
    logic [31:0] MDatain, MAR_data_out;
    logic        mem_busy, mem_ready, mem_err;

    memory_interface #(
        .DEPTH       (MEM_DEPTH),
        .ADDR_W      (MEM_ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .bus_contents (bus_contents),
        .MARin        (MARin),
        .MDR_data_out (MDR_data_out),
        .Read         (Read),
        .Write        (Write),
        .MDatain      (MDatain),
        .MAR_data_out (MAR_data_out),
        .mem_busy     (mem_busy),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // kind: 0 read completion, 1 write completion, 2 illegal request
    typedef struct {
        int          due;
        int          kind;
        bit          dknown;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];

    // Reference model: memory image, MAR, last read value, one in-flight request.
    logic [31:0] m_mem   [MEM_DEPTH];
    bit          m_known [MEM_DEPTH];
    logic [31:0] m_mar;
    logic [31:0] m_mdat;
    bit          m_mdat_known = 1'b0;
    bit          m_flight = 1'b0;
    int          m_done_edge;
    int          m_kind;
    int          m_addr;
    logic [31:0] m_wdata;
    int          edge_n = 0;
    int          mon_n  = 0;
    bit          chk_en = 1'b0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge.
    task automatic step(input bit c, input bit mi, input logic [31:0] bus,
                        input bit rd, input bit wr, input logic [31:0] mdr);
        bit   idle_before;
        int   a;
        exp_t e;
        clr = c; MARin = mi; bus_contents = bus; Read = rd; Write = wr; MDR_data_out = mdr;
        @(posedge clk);
        edge_n++;
        idle_before = !m_flight;
        if (c) begin
            m_mar = '0;
            m_mdat = '0;
            m_mdat_known = 1'b1;
            if (m_flight && edge_n <= m_done_edge) begin
                while (sbq.size() > 0 && sbq[$].due >= edge_n) void'(sbq.pop_back());
            end
            m_flight = 1'b0;
        end else begin
            if (m_flight && edge_n == m_done_edge) begin
                if (m_kind == 1) begin
                    m_mem[m_addr]   = m_wdata;
                    m_known[m_addr] = 1'b1;
                end else begin
                    m_mdat       = m_mem[m_addr];
                    m_mdat_known = m_known[m_addr];
                end
            end else if (m_flight && edge_n == m_done_edge + 1) begin
                m_flight = 1'b0;
            end
            if (idle_before) begin
                a = mi ? int'(bus[MEM_ADDR_W-1:0]) : int'(m_mar[MEM_ADDR_W-1:0]);
                if (rd && wr) begin
                    e.due = edge_n; e.kind = 2; e.dknown = 1'b0; e.data = '0;
                    sbq.push_back(e);
                end else if (rd || wr) begin
                    m_flight    = 1'b1;
                    m_kind      = rd ? 0 : 1;
                    m_addr      = a;
                    m_wdata     = mdr;
                    m_done_edge = edge_n + WS + 1;
                    e.due = m_done_edge; e.kind = m_kind;
                    e.dknown = rd && m_known[a]; e.data = m_mem[a];
                    sbq.push_back(e);
                end
            end
            if (mi) m_mar = bus;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0);
    endtask

    task automatic wait_free();
        for (int i = 0; i < 40 && m_flight; i++) step(0, 0, '0, 0, 0, '0);
    endtask

    // Called right after the request edge: latency in edges and busy cycles.
    task automatic measure(output int lat, output int nbusy);
        lat = -1;
        nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            if (mem_busy) nbusy++;
            step(0, 0, '0, 0, 0, '0);
            if (mem_ready && lat < 0) lat = i;
            if (!mem_busy) break;
        end
    endtask

    // Monitor: completions and errors must appear exactly when due; levels track the model.
    always @(negedge clk) begin
        mon_n++;
        if (chk_en) begin
            if (sbq.size() > 0 && sbq[0].due == mon_n) begin
                mon_e = sbq.pop_front();
                if (mon_e.kind == 2) begin
                    check("err_pulse", {31'b0, mem_err}, 32'd1);
                    check("err_no_ready", {31'b0, mem_ready}, 32'd0);
                end else begin
                    check("ready_pulse", {31'b0, mem_ready}, 32'd1);
                    check("ready_no_err", {31'b0, mem_err}, 32'd0);
                    if (mon_e.kind == 0 && mon_e.dknown) check("read_data", MDatain, mon_e.data);
                end
            end else begin
                check("ready_idle", {31'b0, mem_ready}, 32'd0);
                check("err_idle", {31'b0, mem_err}, 32'd0);
            end
            check("busy", {31'b0, mem_busy}, {31'b0, m_flight});
            check("mar", MAR_data_out, m_mar);
            if (m_mdat_known) check("mdatain_hold", MDatain, m_mdat);
        end
    end

    initial begin
        int lat, nbusy, r;
        bit c, mi, rd, wr;
        logic [31:0] bus;

        for (int i = 0; i < MEM_DEPTH; i++) m_known[i] = 1'b0;
        m_mar = '0;
        m_mdat = '0;

        repeat (3) step(1, 0, '0, 0, 0, '0);
        chk_en = 1'b1;
        check("reset_mdatain", MDatain, 32'h0);
        check("reset_mar", MAR_data_out, 32'h0);
        check("reset_flags", {29'b0, mem_busy, mem_ready, mem_err}, 32'h0);

        // Write 0xDEADBEEF to address 5.
        step(0, 1, 32'h0000_0005, 0, 0, '0);
        step(0, 0, '0, 0, 1, 32'hDEAD_BEEF);
        measure(lat, nbusy);
        check("wr_latency", lat, WS + 1);
        wait_free();

        // Read it back from MAR=5.
        step(0, 0, '0, 1, 0, '0);
        measure(lat, nbusy);
        check("rd_latency", lat, WS + 1);
        check("rd_busy_cycles", nbusy, WS + 2);
        check("rd_deadbeef", MDatain, 32'hDEAD_BEEF);
        wait_free();

        // Bypass: MAR load and Read on the same edge use bus bits [8:0].
        step(0, 1, 32'h0000_0007, 0, 0, '0);
        step(0, 0, '0, 0, 1, 32'hCAFE_0007);
        wait_free();
        step(0, 1, 32'h0000_0040, 0, 0, '0);
        step(0, 1, 32'h0000_0207, 1, 0, '0);
        wait_free();
        check("bypass_data", MDatain, 32'hCAFE_0007);
        check("bypass_mar", MAR_data_out, 32'h0000_0207);

        // Read and Write together: error pulse, no request.
        step(0, 0, '0, 1, 1, 32'h1111_1111);
        check("rw_err", {31'b0, mem_err}, 32'd1);
        check("rw_not_busy", {31'b0, mem_busy}, 32'd0);
        idle(1);
        check("rw_err_one_cycle", {31'b0, mem_err}, 32'd0);
        step(0, 0, '0, 1, 0, '0);
        wait_free();
        check("rw_mem_unchanged", MDatain, 32'hCAFE_0007);

        // Clear one edge into a write to address 9 aborts it.
        step(0, 1, 32'h0000_0009, 0, 0, '0);
        step(0, 0, '0, 0, 1, 32'hAAAA_5555);
        wait_free();
        step(0, 0, '0, 0, 1, 32'h1234_5678);
        step(1, 0, '0, 0, 0, '0);
        check("clr_outputs", MDatain | MAR_data_out | {29'b0, mem_busy, mem_ready, mem_err}, 32'h0);
        idle(WS + 4);
        step(0, 1, 32'h0000_0009, 1, 0, '0);
        wait_free();
        check("clr_mem9_kept", MDatain, 32'hAAAA_5555);

        // Re-asserted Read and MAR change mid-request: one completion from address 5.
        step(0, 1, 32'h0000_0005, 1, 0, '0);
        step(0, 1, 32'h0000_0009, 1, 0, '0);
        step(0, 0, '0, 1, 1, '0);
        wait_free();
        check("midreq_data", MDatain, 32'hDEAD_BEEF);
        idle(2);

        // Random traffic over a small address window with random upper MAR bits.
        for (int n = 0; n < 3000; n++) begin
            c   = ($urandom_range(0, 49) == 0);
            mi  = ($urandom_range(0, 2) == 0);
            bus = ($urandom() & 32'hFFFF_FE00) | 32'($urandom_range(0, 15));
            r   = $urandom_range(0, 9);
            rd  = (r < 3) || (r == 9);
            wr  = (r >= 3 && r < 6) || (r == 9);
            step(c, mi, bus, rd, wr, $urandom());
        end

        wait_free();
        idle(4);
        check("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
